// File: rtl/uart_port.sv
// Single-clock UART: tick-enabled baud timebase, valid/ready transmitter and
// oversampling receiver with glitch rejection. Define UART_LOOPBACK_EN to add an internal txd->rx loopback.
module uart_port #(
  parameter int CLOCK_RATE = 200_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 txd,
  output logic                 tx_busy,
  input  logic                 rxd,
`ifdef UART_LOOPBACK_EN
  input  logic                 loopback,
`endif
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 parity_error,
  output logic                 framing_error
);

  localparam int DIV   = (CLOCK_RATE + (BAUD_RATE * OVERSAMPLE) / 2) / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SUB_W = $clog2(OVERSAMPLE);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(OVERSAMPLE - 1);
  localparam logic [SUB_W-1:0] HALF_LAST = SUB_W'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic             PAR_ODD   = (PARITY == 1);

  if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      (STOP_BITS != 1 && STOP_BITS != 2) || OVERSAMPLE < 8 ||
      (OVERSAMPLE % 2) != 0 || DIV < 1) begin : g_param_check
    $error("uart_port: illegal parameter combination");
  end

  // Baud timebase: one-clock enable every DIV clocks
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  // Transmitter. Handshake: a byte transfers on any clock where
  // tx_valid && tx_ready; tx_ready is high only in TX_IDLE.
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  tx_state_t            tx_state;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par;
  logic [SUB_W-1:0]     tx_sub;
  logic [3:0]           tx_bit;
  logic                 tx_bit_end;
  assign tx_bit_end = tick && (tx_sub == SUB_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      txd      <= 1'b1;
      tx_ready <= 1'b1;
      tx_busy  <= 1'b0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      tx_sub   <= '0;
      tx_bit   <= '0;
    end else begin
      if (tx_state != TX_IDLE && tick)
        tx_sub <= tx_bit_end ? '0 : tx_sub + 1'b1;
      case (tx_state)
        TX_IDLE: if (tx_valid && tx_ready) begin
          tx_shift <= tx_data;
          tx_par   <= (^tx_data) ^ PAR_ODD;
          tx_sub   <= '0;
          tx_bit   <= '0;
          txd      <= 1'b0;
          tx_ready <= 1'b0;
          tx_busy  <= 1'b1;
          tx_state <= TX_START;
        end
        TX_START: if (tx_bit_end) begin
          txd      <= tx_shift[0];
          tx_shift <= tx_shift >> 1;
          tx_bit   <= '0;
          tx_state <= TX_DATA;
        end
        TX_DATA: if (tx_bit_end) begin
          if (tx_bit == DATA_LAST) begin
            tx_bit <= '0;
            if (PARITY != 0) begin
              txd      <= tx_par;
              tx_state <= TX_PARITY;
            end else begin
              txd      <= 1'b1;
              tx_state <= TX_STOP;
            end
          end else begin
            txd      <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
            tx_bit   <= tx_bit + 1'b1;
          end
        end
        TX_PARITY: if (tx_bit_end) begin
          txd      <= 1'b1;
          tx_bit   <= '0;
          tx_state <= TX_STOP;
        end
        TX_STOP: if (tx_bit_end) begin
          if (tx_bit == STOP_LAST) begin
            tx_ready <= 1'b1;
            tx_busy  <= 1'b0;
            tx_state <= TX_IDLE;
          end else begin
            tx_bit <= tx_bit + 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // Receiver front end: 2-FF synchroniser and falling-edge detect
  logic rx_in, rx_s1, rx_s2, rx_prev, rx_fall;
`ifdef UART_LOOPBACK_EN
  assign rx_in = loopback ? txd : rxd;
`else
  assign rx_in = rxd;
`endif
  assign rx_fall = rx_prev && !rx_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx_in;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;
  rx_state_t            rx_state;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_par_bit;
  logic [SUB_W-1:0]     rx_sub;
  logic [3:0]           rx_bit;
  logic                 rx_bit_end;
  assign rx_bit_end = tick && (rx_sub == SUB_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state      <= RX_IDLE;
      rx_shift      <= '0;
      rx_par_bit    <= 1'b0;
      rx_sub        <= '0;
      rx_bit        <= '0;
      rx_valid      <= 1'b0;
      rx_data       <= '0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if ((rx_state == RX_DATA || rx_state == RX_PARITY || rx_state == RX_STOP) && tick)
        rx_sub <= rx_bit_end ? '0 : rx_sub + 1'b1;
      case (rx_state)
        RX_IDLE: if (rx_fall) begin
          rx_sub   <= '0;
          rx_state <= RX_START;
        end
        // Half a bit in: a high line here means the edge was a glitch
        RX_START: if (tick) begin
          if (rx_sub == HALF_LAST) begin
            rx_sub   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            rx_sub <= rx_sub + 1'b1;
          end
        end
        RX_DATA: if (rx_bit_end) begin
          rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
          if (rx_bit == DATA_LAST)
            rx_state <= (PARITY != 0) ? RX_PARITY : RX_STOP;
          else
            rx_bit <= rx_bit + 1'b1;
        end
        RX_PARITY: if (rx_bit_end) begin
          rx_par_bit <= rx_s2;
          rx_state   <= RX_STOP;
        end
        RX_STOP: if (rx_bit_end) begin
          rx_valid      <= 1'b1;
          rx_data       <= rx_shift;
          parity_error  <= (PARITY != 0) && (rx_par_bit != ((^rx_shift) ^ PAR_ODD));
          framing_error <= !rx_s2;
          rx_state      <= rx_s2 ? RX_IDLE : RX_WAIT_HIGH;
        end
        RX_WAIT_HIGH: if (rx_s2) rx_state <= RX_IDLE;
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule
